// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with a configurable frame format. A FIFO queues words, and the
// serialiser sends back-to-back frames with no idle gap between them.
module uart_tx_cfg #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_din,
  input  logic                          tx_din_vld,
  output logic                          tx_din_rdy,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow
);

  localparam int unsigned BaudDiv = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BaudW   = $clog2(BaudDiv);
  localparam int unsigned BitW    = $clog2(DATA_BITS);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic [BaudW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

  logic                   push, pop, fifo_empty, baud_end;
  logic [DATA_BITS-1:0]   head;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) return ~^d;
    return ^d;
  endfunction

  assign tx_din_rdy = (cnt_q != CntW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = tx_din_vld && tx_din_rdy;
  assign head       = mem[rd_ptr_q];
  assign baud_end   = (baud_q == BaudW'(BaudDiv - 1));

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;
  assign fifo_cnt = cnt_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = parity_of(head);
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_end) begin
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = StStop;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (baud_end) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (baud_end) begin
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit so frames stay contiguous.
            pop     = 1'b1;
            shift_d = head;
            par_d   = parity_of(head);
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = tx_din_vld && !tx_din_rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_din;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: five instances cover 8N1, even/odd parity, a shallow FIFO
// and a 7-bit, two-stop-bit format.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din  [5];
  logic       vld  [5];
  logic       tx_w [5];
  logic       rdy_w[5];
  logic       busy_w[5];
  logic       ovf_w[5];
  logic [4:0] cnt0, cnt1, cnt2, cnt4;
  logic [2:0] cnt3;

  int n_chk  = 0;
  int n_fail = 0;
  int fall_wait;
  int ovf3_pulses = 0;
  logic [15:0] cap [16];

  always #5 clk = ~clk;

  // Inst 0: defaults (div 434, 8N1, depth 16).
  uart_tx_cfg u0 (.clk(clk), .rst_n(rst_n), .tx_din(din[0]), .tx_din_vld(vld[0]),
    .tx_din_rdy(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_cnt(cnt0),
    .overflow(ovf_w[0]));
  // Inst 1: even parity, div 8.
  uart_tx_cfg #(.CLK_FREQ(921_600), .PARITY(2)) u1 (.clk(clk), .rst_n(rst_n),
    .tx_din(din[1]), .tx_din_vld(vld[1]), .tx_din_rdy(rdy_w[1]), .tx(tx_w[1]),
    .busy(busy_w[1]), .fifo_cnt(cnt1), .overflow(ovf_w[1]));
  // Inst 2: odd parity, div 8.
  uart_tx_cfg #(.CLK_FREQ(921_600), .PARITY(1)) u2 (.clk(clk), .rst_n(rst_n),
    .tx_din(din[2]), .tx_din_vld(vld[2]), .tx_din_rdy(rdy_w[2]), .tx(tx_w[2]),
    .busy(busy_w[2]), .fifo_cnt(cnt2), .overflow(ovf_w[2]));
  // Inst 3: 4-deep FIFO, div 8.
  uart_tx_cfg #(.CLK_FREQ(921_600), .FIFO_DEPTH(4)) u3 (.clk(clk), .rst_n(rst_n),
    .tx_din(din[3]), .tx_din_vld(vld[3]), .tx_din_rdy(rdy_w[3]), .tx(tx_w[3]),
    .busy(busy_w[3]), .fifo_cnt(cnt3), .overflow(ovf_w[3]));
  // Inst 4: 7 data bits, 2 stop bits, div 434.
  uart_tx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u4 (.clk(clk), .rst_n(rst_n),
    .tx_din(din[4][6:0]), .tx_din_vld(vld[4]), .tx_din_rdy(rdy_w[4]), .tx(tx_w[4]),
    .busy(busy_w[4]), .fifo_cnt(cnt4), .overflow(ovf_w[4]));

  always @(negedge clk) if (ovf_w[3]) ovf3_pulses++;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         nbits;
    int         div;
    int         exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int get_cnt(input int idx);
    case (idx)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      3:       return int'(cnt3);
      default: return int'(cnt4);
    endcase
  endfunction

  // Called at a sample point (#1 after an edge). k0 < 0: wait for the start bit first;
  // otherwise k0 is the number of cycles already elapsed since tx fell.
  task automatic capture(input int idx, input int nfr, input int nbits, input int div,
                         input int k0, output int len);
    int k;
    int pos;
    for (int f = 0; f < 16; f++) cap[f] = '0;
    len       = -1;
    fall_wait = 0;
    if (k0 < 0) begin
      while (tx_w[idx] == 1'b1 && fall_wait < 50) begin
        @(posedge clk); #1;
        fall_wait++;
      end
      k = 0;
    end else begin
      k = k0;
    end
    for (int c = 0; c < nfr * nbits * div + 20; c++) begin
      if (busy_w[idx] == 1'b0) begin
        len = k;
        break;
      end
      if (k % div == div / 2) begin
        pos = k / div;
        if (pos / nbits < nfr) cap[pos / nbits][pos % nbits] = tx_w[idx];
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Writes n words on consecutive edges with vld held high; returns peak fifo_cnt.
  task automatic burst(input int idx, input int n, input logic [7:0] w [8], output int peak);
    peak = 0;
    for (int i = 0; i < n; i++) begin
      din[idx] = w[i];
      vld[idx] = 1'b1;
      @(posedge clk); #1;
      if (get_cnt(idx) > peak) peak = get_cnt(idx);
      if (idx == 3 && i == 4) begin
        chk("d_cnt_full", get_cnt(3), 4);
        chk("d_rdy_full", int'(rdy_w[3]), 0);
      end
    end
    vld[idx] = 1'b0;
  endtask

  vec_t       vecs [6];
  logic [7:0] words [8];
  int         len, peak, lows;

  initial begin
    for (int i = 0; i < 5; i++) begin
      din[i] = '0;
      vld[i] = 1'b0;
    end
    vecs[0] = '{idx: 0, data: 8'hAA, nbits: 10, div: 434, exp: 'h354};
    vecs[1] = '{idx: 1, data: 8'hEF, nbits: 11, div: 8,   exp: 'h7DE};
    vecs[2] = '{idx: 1, data: 8'h00, nbits: 11, div: 8,   exp: 'h400};
    vecs[3] = '{idx: 2, data: 8'hAA, nbits: 11, div: 8,   exp: 'h754};
    vecs[4] = '{idx: 2, data: 8'h00, nbits: 11, div: 8,   exp: 'h600};
    vecs[5] = '{idx: 4, data: 8'h5A, nbits: 10, div: 434, exp: 'h3B4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(tx_w[0]), 1);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_rdy", int'(rdy_w[3]), 1);
    chk("rst_cnt", int'(cnt0), 0);
    chk("rst_ovf", int'(ovf_w[3]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frames through the vector table.
    foreach (vecs[v]) begin
      din[vecs[v].idx] = vecs[v].data;
      vld[vecs[v].idx] = 1'b1;
      @(posedge clk); #1;
      vld[vecs[v].idx] = 1'b0;
      chk($sformatf("v%0d_tx_after_accept", v), int'(tx_w[vecs[v].idx]), 1);
      chk($sformatf("v%0d_busy_after_accept", v), int'(busy_w[vecs[v].idx]), 1);
      capture(vecs[v].idx, 1, vecs[v].nbits, vecs[v].div, -1, len);
      chk($sformatf("v%0d_start_latency", v), fall_wait, 1);
      chk($sformatf("v%0d_frame", v), int'(cap[0]), vecs[v].exp);
      chk($sformatf("v%0d_length", v), len, vecs[v].nbits * vecs[v].div);
      chk($sformatf("v%0d_idle_tx", v), int'(tx_w[vecs[v].idx]), 1);
      repeat (2) @(posedge clk);
      #1;
    end

    // Eight-word burst: contiguous frames, decoded as a loopback receiver would.
    words = '{8'hAA, 8'h55, 8'hEF, 8'hAE, 8'h11, 8'h22, 8'h33, 8'h44};
    burst(0, 8, words, peak);
    chk("burst_peak_cnt", peak, 7);
    capture(0, 8, 10, 434, 6, len);
    for (int f = 0; f < 8; f++)
      chk($sformatf("burst_frame%0d", f), int'(cap[f]), 'h200 | (int'(words[f]) << 1));
    chk("burst_length", len, 8 * 10 * 434);

    // Shallow FIFO: six writes, five accepted, one overflow pulse.
    words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    burst(3, 6, words, peak);
    chk("d_cnt_after_drop", int'(cnt3), 4);
    capture(3, 5, 10, 8, 4, len);
    for (int f = 0; f < 5; f++)
      chk($sformatf("d_frame%0d", f), int'(cap[f]), 'h200 | ((f + 1) << 1));
    chk("d_length", len, 5 * 10 * 8);
    chk("d_overflow_pulses", ovf3_pulses, 1);

    // Asynchronous reset in the middle of the second of three queued frames.
    words = '{8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    burst(0, 3, words, peak);
    repeat (10 * 434 + 3 * 434 + 217 - 1) @(posedge clk);
    #3;
    chk("mid_tx_before_rst", int'(busy_w[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx_w[0]), 1);
    chk("mid_rst_busy", int'(busy_w[0]), 0);
    chk("mid_rst_cnt", int'(cnt0), 0);
    chk("mid_rst_rdy", int'(rdy_w[0]), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lows = 0;
    for (int c = 0; c < 3 * 10 * 434; c++) begin
      @(posedge clk); #1;
      if (tx_w[0] == 1'b0 || busy_w[0] == 1'b1) lows++;
    end
    chk("mid_no_frames_after_rst", lows, 0);
    chk("mid_cnt_after_rst", int'(cnt0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
